// File: rtl/vga_line_fetch_if.sv
// Memory read port of the line fetcher: single outstanding word request with same-cycle data on ack.
interface vga_line_fetch_if #(
  parameter int unsigned C_addr_bits = 20
);
  logic [C_addr_bits-1:0] mem_addr;
  logic                   mem_req;
  logic                   mem_ack;
  logic [31:0]            mem_data;

  // Fetcher side: drives the request and address, receives ack and data.
  modport master (
    output mem_addr,
    output mem_req,
    input  mem_ack,
    input  mem_data
  );

  // Memory side: observes the request, returns ack and data.
  modport slave (
    input  mem_addr,
    input  mem_req,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/vga_line_fetch.sv
// Line fetcher: prefetches 24-bit pixel words from memory into a show-ahead FIFO,
// pops them at the pixel rate, and rewinds on frame start or on a line replay.
module vga_line_fetch #(
  parameter int unsigned C_resolution_x = 640,
  parameter int unsigned C_resolution_y = 480,
  parameter int unsigned C_addr_bits    = 20,
  parameter int unsigned C_base_addr    = 0,
  parameter int unsigned C_fifo_bits    = 4,
  parameter int unsigned C_dbl_y        = 0
) (
  input  logic             clk_pixel,
  input  logic             rst_n,
  input  logic             clk_pixel_ena,
  input  logic             fetch_next,
  input  logic             line_repeat,
  input  logic             vga_vblank,
  output logic [7:0]       red_byte,
  output logic [7:0]       green_byte,
  output logic [7:0]       blue_byte,
  output logic             underflow,
  vga_line_fetch_if.master mem
);

  localparam int unsigned AW    = C_addr_bits;
  localparam int unsigned FB    = C_fifo_bits;
  localparam int unsigned DEPTH = 2 ** FB;
  localparam int unsigned XW    = (C_resolution_x > 1) ? $clog2(C_resolution_x) : 1;

  localparam logic [AW-1:0] BASE     = AW'(C_base_addr);
  localparam logic [AW-1:0] END_ADDR = AW'(C_base_addr + C_resolution_x * C_resolution_y);
  localparam logic [AW-1:0] LINE_LEN = AW'(C_resolution_x);
  localparam logic [XW-1:0] X_LAST   = XW'(C_resolution_x - 1);
  localparam bit            DBL_EN   = (C_dbl_y != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          req_nxt;
  logic [AW-1:0] addr_nxt;

  logic [23:0]   fifo_mem [DEPTH];
  logic [FB-1:0] wr_ptr;
  logic [FB-1:0] rd_ptr;
  logic [FB:0]   count;
  logic [23:0]   last_pix;
  logic [23:0]   head;

  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] cur_line_start;
  logic [AW-1:0] last_line_start;
  logic [XW-1:0] x_cnt;

  logic vblank_q;
  logic repeat_q;

  logic vblank_rise;
  logic repeat_rise;
  logic flush;
  logic fifo_empty;
  logic pop_try;
  logic pop;
  logic push;
  logic occ_ok;
  logic addr_ok;
  logic can_fetch;
  logic unused_ok;

  // Edge qualification: vblank wins over a simultaneous replay request.
  assign vblank_rise = vga_vblank & ~vblank_q;
  assign repeat_rise = DBL_EN & line_repeat & ~repeat_q & ~vblank_rise;
  assign flush       = vblank_rise | repeat_rise;

  // Consumer side: attempted pops always count, real pops only when data is present.
  assign fifo_empty = (count == '0);
  assign pop_try    = fetch_next & clk_pixel_ena;
  assign pop        = pop_try & ~fifo_empty;

  // Producer side: a word returned during a flush or for a discarded request is dropped.
  assign push = (state == REQ) & mem.mem_ack & ~flush;

  // Request gating: room for the word, still inside the frame, not rewinding.
  assign occ_ok    = (({1'b0, count} + (FB+2)'(state != IDLE)) < (FB+2)'(DEPTH));
  assign addr_ok   = (fetch_addr < END_ADDR);
  assign can_fetch = occ_ok & addr_ok & ~flush;

  // Alpha byte of the memory word carries nothing for this block.
  assign unused_ok = &{1'b0, mem.mem_data[31:24]};

  // Edge-detector history, sampled every pixel clock regardless of enable.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      vblank_q <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      vblank_q <= vga_vblank;
      repeat_q <= line_repeat;
    end
  end

  // Fetch FSM state register plus registered request outputs.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= BASE;
    end else begin
      state        <= state_nxt;
      mem.mem_req  <= req_nxt;
      mem.mem_addr <= addr_nxt;
    end
  end

  // Fetch FSM next state: a flush while waiting turns the request into a discard.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (can_fetch) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (mem.mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch FSM outputs: address is captured on request launch and held until ack.
  always_comb begin
    req_nxt  = (state_nxt != IDLE);
    addr_nxt = mem.mem_addr;
    if ((state == IDLE) && (state_nxt == REQ)) begin
      addr_nxt = fetch_addr;
    end
  end

  // FIFO pointers and occupancy; a flush empties it in one cycle.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FB'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FB'(1);
      end
      if (push && !pop) begin
        count <= count + (FB+1)'(1);
      end else if (pop && !push) begin
        count <= count - (FB+1)'(1);
      end
    end
  end

  // FIFO storage; contents are only observed while occupancy is non-zero.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem.mem_data[23:0];
    end
  end

  // Last popped pixel (shown while empty) and sticky underflow.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      last_pix  <= '0;
      underflow <= 1'b0;
    end else begin
      if (pop) begin
        last_pix <= fifo_mem[rd_ptr];
      end
      if (pop_try && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Consume counters: pixel position and start addresses of the current and previous line.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt           <= '0;
      cur_line_start  <= BASE;
      last_line_start <= BASE;
    end else if (vblank_rise) begin
      x_cnt           <= '0;
      cur_line_start  <= BASE;
      last_line_start <= BASE;
    end else begin
      if (pop_try) begin
        if (x_cnt == X_LAST) begin
          x_cnt           <= '0;
          last_line_start <= cur_line_start;
          cur_line_start  <= cur_line_start + LINE_LEN;
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
      end
      if (repeat_rise) begin
        cur_line_start <= last_line_start;
      end
    end
  end

  // Next word address to fetch; rewinds on flush, advances only on accepted words.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr <= BASE;
    end else if (vblank_rise) begin
      fetch_addr <= BASE;
    end else if (repeat_rise) begin
      fetch_addr <= last_line_start;
    end else if (push) begin
      fetch_addr <= fetch_addr + AW'(1);
    end
  end

  // Show-ahead pixel: FIFO head when available, otherwise hold the last popped value.
  always_comb begin
    head = last_pix;
    if (!fifo_empty) begin
      head = fifo_mem[rd_ptr];
    end
  end

  assign red_byte   = head[23:16];
  assign green_byte = head[15:8];
  assign blue_byte  = head[7:0];

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench: one 640x480 fetcher with line doubling and one 4x2 fetcher without.
module tb_vga_line_fetch;

  logic clk;
  logic rst_n;

  logic m_ena, m_next, m_repeat, m_vblank;
  logic [7:0] m_red, m_green, m_blue;
  logic m_underflow;
  logic ack_en;
  logic ovr_en;
  logic [31:0] ovr_data;

  logic s_ena, s_next, s_repeat, s_vblank;
  logic [7:0] s_red, s_green, s_blue;
  logic s_underflow;

  logic [19:0] m_log[$];
  logic [19:0] s_log[$];

  int n_checks;
  int n_errors;

  vga_line_fetch_if #(.C_addr_bits(20)) m_if ();
  vga_line_fetch_if #(.C_addr_bits(20)) s_if ();

  assign m_if.mem_ack  = ack_en;
  assign m_if.mem_data = ovr_en ? ovr_data : 32'(m_if.mem_addr);
  assign s_if.mem_ack  = 1'b1;
  assign s_if.mem_data = 32'(s_if.mem_addr);

  vga_line_fetch #(
    .C_resolution_x(640), .C_resolution_y(480), .C_addr_bits(20),
    .C_base_addr(0), .C_fifo_bits(4), .C_dbl_y(1)
  ) u_main (
    .clk_pixel(clk), .rst_n(rst_n), .clk_pixel_ena(m_ena), .fetch_next(m_next),
    .line_repeat(m_repeat), .vga_vblank(m_vblank),
    .red_byte(m_red), .green_byte(m_green), .blue_byte(m_blue),
    .underflow(m_underflow), .mem(m_if)
  );

  vga_line_fetch #(
    .C_resolution_x(4), .C_resolution_y(2), .C_addr_bits(20),
    .C_base_addr(0), .C_fifo_bits(4), .C_dbl_y(0)
  ) u_small (
    .clk_pixel(clk), .rst_n(rst_n), .clk_pixel_ena(s_ena), .fetch_next(s_next),
    .line_repeat(s_repeat), .vga_vblank(s_vblank),
    .red_byte(s_red), .green_byte(s_green), .blue_byte(s_blue),
    .underflow(s_underflow), .mem(s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed memory handshake address.
  always @(posedge clk) begin
    if (m_if.mem_req && m_if.mem_ack) m_log.push_back(m_if.mem_addr);
    if (s_if.mem_req && s_if.mem_ack) s_log.push_back(s_if.mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the main fetcher to raise mem_req.
  task automatic wait_mreq(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = m_if.mem_req;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // 640 enabled pops, one every third cycle, expecting words 0..639.
  task automatic run_stream(input int pass);
    for (int i = 0; i < 640; i++) begin
      @(negedge clk); m_ena = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("stream%0d_px%0d", pass, i), 32'(m_blue), 32'(i & 255));
      m_ena  = 1'b1;
      m_next = 1'b1;
    end
    @(negedge clk);
    m_ena  = 1'b0;
    m_next = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    m_ena = 0; m_next = 0; m_repeat = 0; m_vblank = 0;
    s_ena = 0; s_next = 0; s_repeat = 0; s_vblank = 0;
    ack_en = 1'b0; ovr_en = 1'b0; ovr_data = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(m_if.mem_req), 32'd0);
    check("rst_mem_addr", 32'(m_if.mem_addr), 32'd0);
    check("rst_underflow", 32'(m_underflow), 32'd0);
    check("rst_pixel", {8'h0, m_red, m_green, m_blue}, 32'h0);

    // Underflow: memory never answers, one enabled pop
    rst_n = 1'b1;
    @(negedge clk);
    check("ufl_req_after_reset", 32'(m_if.mem_req), 32'd1);
    check("ufl_req_addr", 32'(m_if.mem_addr), 32'd0);
    m_ena = 1'b1; m_next = 1'b1;
    @(negedge clk);
    m_ena = 1'b0; m_next = 1'b0;
    check("ufl_set", 32'(m_underflow), 32'd1);
    check("ufl_pixel_held", 32'(m_blue), 32'd0);
    repeat (5) @(negedge clk);
    check("ufl_sticky", 32'(m_underflow), 32'd1);
    check("ufl_req_held", 32'(m_if.mem_req), 32'd1);
    check("ufl_addr_held", 32'(m_if.mem_addr), 32'd0);

    // Reset mid-transaction, then fill with memory always acking
    rst_n = 1'b0;
    ack_en = 1'b1;
    m_log.delete();
    @(negedge clk);
    check("ufl_cleared_by_reset", 32'(m_underflow), 32'd0);
    check("midreset_req_dropped", 32'(m_if.mem_req), 32'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("fill_count", 32'(m_log.size()), 32'd16);
    if (m_log.size() == 16) begin
      for (int i = 0; i < 16; i++) check($sformatf("fill_addr%0d", i), 32'(m_log[i]), 32'(i));
    end
    check("fill_req_idle", 32'(m_if.mem_req), 32'd0);
    check("fill_head", 32'(m_blue), 32'd0);

    // Stream line 0
    run_stream(1);
    check("stream1_underflow", 32'(m_underflow), 32'd0);

    // Line replay: rewind to the previous line start
    @(negedge clk);
    m_repeat = 1'b1;
    @(negedge clk);
    m_repeat = 1'b0;
    m_log.delete();
    wait_mreq("repeat_req_seen");
    check("repeat_addr", 32'(m_if.mem_addr), 32'd0);
    repeat (40) @(negedge clk);
    run_stream(2);
    check("stream2_underflow", 32'(m_underflow), 32'd0);

    // Discard: vblank while a request at address 5 is pending
    rst_n = 1'b0;
    m_log.delete();
    s_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100 && m_log.size() < 5; k++) @(negedge clk);
    ack_en = 1'b0;
    check("disc_pre_count", 32'(m_log.size()), 32'd5);
    wait_mreq("disc_req_seen");
    check("disc_pending_addr", 32'(m_if.mem_addr), 32'd5);
    ovr_en = 1'b1;
    ovr_data = 32'h0000_00AA;
    m_vblank = 1'b1;
    @(negedge clk);
    check("disc_req_held", 32'(m_if.mem_req), 32'd1);
    check("disc_addr_held", 32'(m_if.mem_addr), 32'd5);
    ack_en = 1'b1;
    @(negedge clk);
    ovr_en = 1'b0;
    check("disc_req_released", 32'(m_if.mem_req), 32'd0);
    wait_mreq("disc_next_req_seen");
    check("disc_next_addr", 32'(m_if.mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    check("disc_head_not_aa", 32'(m_blue), 32'd0);
    m_vblank = 1'b0;

    // Frame end on the 4x2 fetcher
    check("small_count", 32'(s_log.size()), 32'd8);
    if (s_log.size() == 8) begin
      for (int i = 0; i < 8; i++) check($sformatf("small_addr%0d", i), 32'(s_log[i]), 32'(i));
    end
    check("small_req_stopped", 32'(s_if.mem_req), 32'd0);
    s_repeat = 1'b1;
    @(negedge clk);
    s_repeat = 1'b0;
    repeat (6) @(negedge clk);
    check("small_repeat_ignored_req", 32'(s_if.mem_req), 32'd0);
    check("small_repeat_ignored_count", 32'(s_log.size()), 32'd8);
    s_log.delete();
    s_vblank = 1'b1;
    @(negedge clk);
    s_vblank = 1'b0;
    repeat (30) @(negedge clk);
    check("small_refetch_count", 32'(s_log.size()), 32'd8);
    if (s_log.size() == 8) begin
      check("small_refetch_first", 32'(s_log[0]), 32'd0);
      check("small_refetch_last", 32'(s_log[7]), 32'd7);
    end
    check("small_underflow", 32'(s_underflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
